freq_div_prog: RTL and testbench

- Multi-channel, run-time programmable clock-enable/divided-clock generator driven from the 100 MHz system clock.
- Each channel produces a divided output with programmable period and high time, plus a one-cycle tick at each period start.
- New ratios load through a shadow register and take effect only at a period boundary, so the output never glitches.
- Sits beside the fixed divide-by-8 divider and replaces it wherever ratio, duty or channel count must vary.

---
 rtl/freq_div_pkg.sv | 19 +
 rtl/freq_div_chan.sv | 108 ++++++++++
 rtl/freq_div_prog.sv | 38 +++
 tb/tb_freq_div_prog.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared types, legal-range constants and the config legality check
// used by every divider channel.
package freq_div_pkg;

    localparam int unsigned DIV_MIN  = 2;
    localparam int unsigned HIGH_MIN = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // A ratio is legal when the period is at least two cycles and the high
    // time leaves at least one low cycle.
    function automatic logic cfg_valid(input int unsigned div, input int unsigned high);
        return (div >= DIV_MIN) && (high >= HIGH_MIN) && (high < div);
    endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One programmable divider channel: shadow/active config, IDLE/RUN control,
// period counter and registered clk_out/tick outputs.
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEF_DIV  = 8,
    parameter int DEF_HIGH = 4
) (
    input  logic         clk_100,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] div_in,
    input  logic [W-1:0] high_in,
    output logic         clk_out,
    output logic         tick,
    output logic         cfg_err
);

    typedef struct packed {
        logic [W-1:0] div;
        logic [W-1:0] high;
    } cfg_t;

    localparam cfg_t DEF_CFG = '{div: W'(DEF_DIV), high: W'(DEF_HIGH)};

    chan_state_t  state, state_next;
    logic [W-1:0] cnt, cnt_next;
    cfg_t         active, shadow;
    logic         pending;
    logic         clk_next, tick_next;
    logic         boundary, transfer, cfg_ok, load_ok;

    assign boundary = (state == RUN) && en && (cnt == active.div - 1'b1);
    assign cfg_ok   = cfg_valid(32'(div_in), 32'(high_in));
    assign load_ok  = load && cfg_ok;
    // The shadow only ever reaches active while idle or on a period boundary,
    // so a running period always finishes with the ratio it started with.
    assign transfer = pending && ((state == IDLE) || boundary);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en)  state_next = RUN;
            RUN:     if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        cnt_next  = '0;
        clk_next  = 1'b0;
        tick_next = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    clk_next  = 1'b1;
                    tick_next = 1'b1;
                end
            end
            RUN: begin
                if (en) begin
                    if (boundary) begin
                        clk_next  = 1'b1;
                        tick_next = 1'b1;
                    end else begin
                        cnt_next = cnt + 1'b1;
                        clk_next = (cnt + 1'b1) < active.high;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100 or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= DEF_CFG;
            shadow  <= DEF_CFG;
            pending <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            clk_out <= clk_next;
            tick    <= tick_next;
            if (transfer) active <= shadow;
            if (load_ok)  shadow <= '{div: div_in, high: high_in};
            // A load on the transfer edge re-arms pending for the next boundary.
            if (load_ok)       pending <= 1'b1;
            else if (transfer) pending <= 1'b0;
            if (load) cfg_err <= !cfg_ok;
        end
    end

endmodule

// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider: slices the packed config buses
// and instantiates one independent channel per output.
module freq_div_prog #(
    parameter int W        = 8,
    parameter int CH       = 2,
    parameter int DEF_DIV  = 8,
    parameter int DEF_HIGH = 4
) (
    input  logic            clk_100,
    input  logic            rst,
    input  logic [CH-1:0]   en,
    input  logic [CH-1:0]   load,
    input  logic [CH*W-1:0] div_in,
    input  logic [CH*W-1:0] high_in,
    output logic [CH-1:0]   clk_out,
    output logic [CH-1:0]   tick,
    output logic [CH-1:0]   cfg_err
);

    for (genvar k = 0; k < CH; k++) begin : g_chan
        freq_div_chan #(
            .W        (W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk_100 (clk_100),
            .rst     (rst),
            .en      (en[k]),
            .load    (load[k]),
            .div_in  (div_in[k*W +: W]),
            .high_in (high_in[k*W +: W]),
            .clk_out (clk_out[k]),
            .tick    (tick[k]),
            .cfg_err (cfg_err[k])
        );
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: directed scenarios with literal
// expectations, then randomized traffic against a period-position model.
module tb_freq_div_prog;

    localparam int W  = 8;
    localparam int CH = 2;

    logic            clk_100 = 1'b0;
    logic            rst     = 1'b1;
    logic [CH-1:0]   en      = '0;
    logic [CH-1:0]   load    = '0;
    logic [CH*W-1:0] div_in  = '0;
    logic [CH*W-1:0] high_in = '0;
    logic [CH-1:0]   clk_out, tick, cfg_err;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    freq_div_prog #(.W(W), .CH(CH), .DEF_DIV(8), .DEF_HIGH(4)) dut (
        .clk_100 (clk_100),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .div_in  (div_in),
        .high_in (high_in),
        .clk_out (clk_out),
        .tick    (tick),
        .cfg_err (cfg_err)
    );

    always #5 clk_100 = ~clk_100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: each channel is described by whether it runs, its position in
    // the current period, and the active/shadow ratios.
    int m_run[CH], m_pos[CH], m_div[CH], m_high[CH];
    int m_sdiv[CH], m_shigh[CH], m_pend[CH], m_err[CH];

    always @(posedge clk_100 or posedge rst) begin
        for (int k = 0; k < CH; k++) begin
            if (rst) begin
                m_run[k] = 0; m_pos[k] = 0; m_pend[k] = 0; m_err[k] = 0;
                m_div[k] = 8; m_high[k] = 4; m_sdiv[k] = 8; m_shigh[k] = 4;
            end else begin
                int nd, nh;
                nd = int'(div_in[k*W +: W]);
                nh = int'(high_in[k*W +: W]);
                if (m_run[k] == 0) begin
                    if (m_pend[k] != 0) begin
                        m_div[k] = m_sdiv[k]; m_high[k] = m_shigh[k]; m_pend[k] = 0;
                    end
                    if (en[k]) begin m_run[k] = 1; m_pos[k] = 0; end
                end else if (!en[k]) begin
                    m_run[k] = 0; m_pos[k] = 0;
                end else if (m_pos[k] == m_div[k] - 1) begin
                    m_pos[k] = 0;
                    if (m_pend[k] != 0) begin
                        m_div[k] = m_sdiv[k]; m_high[k] = m_shigh[k]; m_pend[k] = 0;
                    end
                end else begin
                    m_pos[k] = m_pos[k] + 1;
                end
                if (load[k]) begin
                    if (nd >= 2 && nh >= 1 && nh <= nd - 1) begin
                        m_sdiv[k] = nd; m_shigh[k] = nh; m_pend[k] = 1; m_err[k] = 0;
                    end else begin
                        m_err[k] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk_100) begin
        if (cmp_on) begin
            for (int k = 0; k < CH; k++) begin
                logic exp_clk, exp_tick;
                exp_clk  = (m_run[k] != 0) && (m_pos[k] < m_high[k]);
                exp_tick = (m_run[k] != 0) && (m_pos[k] == 0);
                check($sformatf("model clk_out[%0d]", k), 64'(clk_out[k]), 64'(exp_clk));
                check($sformatf("model tick[%0d]", k), 64'(tick[k]), 64'(exp_tick));
                check($sformatf("model cfg_err[%0d]", k), 64'(cfg_err[k]), 64'(m_err[k] != 0));
            end
        end
    end

    task automatic step();
        @(negedge clk_100);
    endtask

    task automatic set_cfg(input int k, input int d, input int h);
        div_in[k*W +: W]  = W'(d);
        high_in[k*W +: W] = W'(h);
    endtask

    task automatic pulse_load(input logic [CH-1:0] mask);
        load = mask;
        step();
        load = '0;
    endtask

    // Samples the current cycle first, then n-1 further cycles.
    task automatic capture(input int k, input int n, output logic [31:0] cs, output logic [31:0] ts);
        cs = '0; ts = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            cs = {cs[30:0], clk_out[k]};
            ts = {ts[30:0], tick[k]};
        end
    endtask

    task automatic wait_tick(input int k);
        for (int i = 0; i < 600; i++) begin
            step();
            if (tick[k]) return;
        end
        check($sformatf("wait_tick[%0d] timeout", k), 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] cs, ts;
        int ones0, ones1, ticks1;

        repeat (3) step();
        rst = 1'b0;
        cmp_on = 1'b1;
        check("reset clk_out", 64'(clk_out), 64'd0);
        check("reset tick", 64'(tick), 64'd0);
        check("reset cfg_err", 64'(cfg_err), 64'd0);

        // Defaults: period 8, high 4, output rises one cycle after en.
        en = 2'b01;
        step();
        capture(0, 16, cs, ts);
        check("default clk pattern", 64'(cs[15:0]), 64'h0000_f0f0);
        check("default tick pattern", 64'(ts[15:0]), 64'h0000_8080);

        // Mid-period load of 5/2 applies at the next boundary.
        repeat (2) step();
        set_cfg(0, 5, 2);
        pulse_load(2'b01);
        wait_tick(0);
        capture(0, 10, cs, ts);
        check("div5 clk pattern", 64'(cs[9:0]), 64'(10'b1100011000));
        check("div5 tick pattern", 64'(ts[9:0]), 64'(10'b1000010000));

        // Illegal 3/3 is rejected; legal 3/1 clears the flag.
        wait_tick(0);
        set_cfg(0, 3, 3);
        pulse_load(2'b01);
        check("cfg_err after illegal", 64'(cfg_err[0]), 64'd1);
        set_cfg(0, 3, 1);
        pulse_load(2'b01);
        check("cfg_err after legal", 64'(cfg_err[0]), 64'd0);
        wait_tick(0);
        capture(0, 6, cs, ts);
        check("div3 clk pattern", 64'(cs[5:0]), 64'(6'b100100));

        // Minimum ratio on ch0 alongside the maximum period on ch1.
        wait_tick(0);
        set_cfg(0, 2, 1);
        pulse_load(2'b01);
        set_cfg(1, 255, 128);
        pulse_load(2'b10);
        en = 2'b11;
        step();
        ones0 = 0; ones1 = 0; ticks1 = 0;
        for (int i = 0; i < 255; i++) begin
            if (i > 0) step();
            if (i < 254) ones0 += int'(clk_out[0]);
            ones1  += int'(clk_out[1]);
            ticks1 += int'(tick[1]);
        end
        check("ch1 high cycles", 64'(ones1), 64'd128);
        check("ch1 ticks per period", 64'(ticks1), 64'd1);
        check("ch0 toggle ones", 64'(ones0), 64'd127);
        step();
        check("ch1 next period tick", 64'(tick[1]), 64'd1);

        // Drop en mid-high, then re-enable for a fresh period.
        repeat (10) step();
        en[1] = 1'b0;
        step();
        check("ch1 off after en low", 64'(clk_out[1]), 64'd0);
        repeat (3) step();
        en[1] = 1'b1;
        step();
        check("ch1 restart tick", 64'(tick[1]), 64'd1);
        check("ch1 restart clk", 64'(clk_out[1]), 64'd1);

        // Async reset between edges clears outputs and the sticky flag.
        set_cfg(1, 1, 1);
        pulse_load(2'b10);
        check("ch1 cfg_err div1", 64'(cfg_err[1]), 64'd1);
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        check("async rst clk_out", 64'(clk_out), 64'd0);
        check("async rst tick", 64'(tick), 64'd0);
        check("async rst cfg_err", 64'(cfg_err), 64'd0);
        step();
        rst = 1'b0;
        step();
        capture(0, 16, cs, ts);
        check("post-reset clk pattern", 64'(cs[15:0]), 64'h0000_f0f0);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 63) == 0) en[k] = ~en[k];
                if ($urandom_range(0, 15) == 0) begin
                    int d, h;
                    d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                    : int'($urandom_range(0, 12));
                    h = int'($urandom_range(0, d + 1));
                    if (h > 255) h = 255;
                    set_cfg(k, d, h);
                    load[k] = 1'b1;
                end else begin
                    load[k] = 1'b0;
                end
            end
            step();
            if ($urandom_range(0, 999) == 0) begin
                load = '0;
                #2 rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end
        load = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
